// File: rtl/pfb_sched_pkg.sv
// Shared definitions for the polyphase decimator MAC scheduler.
//   state_t    : scheduler FSM encoding
//   SAMPLE_W   : input sample width
//   COEF_W     : coefficient width seen by the datapath multiplier
//   PROD_W     : full-precision product width
//   calc_ch_w  : channel-index width; a single channel still gets one bit
package pfb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        MAC   = 2'd2
    } state_t;

    localparam int SAMPLE_W = 12;
    localparam int COEF_W   = 14;
    localparam int PROD_W   = SAMPLE_W + COEF_W;

    function automatic int calc_ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pfb_sched_counters.sv
// Chained position counters for the scheduler: channel is the fastest
// index, then polyphase phase, then history slot.  All three advance
// together on a single pulse at the end of each sample's MAC burst.
// Ports:
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   adv            : advance to the next (chan, phase, slot) position
//   chan           : current channel
//   phase          : current polyphase phase
//   slot           : current history slot within the phase
module pfb_sched_counters
    import pfb_sched_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DECIM        = 4,
    parameter int TAPS         = 4,
    parameter int CH_W         = 3,
    parameter int PH_W         = 2,
    parameter int TP_W         = 2
) (
    input  logic            ap_clk,
    input  logic            ap_rst,
    input  logic            adv,
    output logic [CH_W-1:0] chan,
    output logic [PH_W-1:0] phase,
    output logic [TP_W-1:0] slot
);

    logic chan_wrap;
    logic phase_wrap;

    // Explicit compare so a one-channel build (1-bit chan) stays at zero.
    assign chan_wrap  = (chan == CH_W'(NUM_CHANNELS - 1));
    assign phase_wrap = (phase == PH_W'(DECIM - 1));

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            chan  <= '0;
            phase <= '0;
            slot  <= '0;
        end else if (adv) begin
            chan <= chan_wrap ? '0 : chan + CH_W'(1);
            if (chan_wrap) begin
                // DECIM and TAPS are powers of two: natural binary wrap.
                phase <= phase + PH_W'(1);
                if (phase_wrap) begin
                    slot <= slot + TP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pfb_mac_scheduler.sv
// Sequencer that time-shares one multiplier of a multichannel polyphase
// decimator.  Each accepted sample is written to the external history RAM,
// then TAPS multiply-accumulate commands are issued against that RAM and
// the coefficient ROM.  No sample or coefficient storage lives here.
//
// state | meaning
// IDLE  | s_ready high, waiting for an input sample
// WRITE | one cycle, history RAM write of the captured sample
// MAC   | TAPS cycles, one command per tap k = 0..TAPS-1
//
// Ports:
//   ap_clk, ap_rst            : clock, synchronous active-high reset
//   s_valid, s_ready, s_data  : input sample handshake
//   hist_we, hist_waddr,
//   hist_wdata                : history write {chan, phase, slot}
//   hist_re, hist_raddr       : history read {chan, phase, slot-k}
//   coef_raddr                : coefficient index {k, ~phase}
//   mac_valid, mac_first,
//   mac_last, mac_chan        : command strobe, accumulator clear/complete,
//                               accumulator bank
// Address outputs hold their last value while their strobe is low.
module pfb_mac_scheduler
    import pfb_sched_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DECIM        = 4,
    parameter int TAPS         = 4,
    localparam int CH_W        = calc_ch_w(NUM_CHANNELS),
    localparam int PH_W        = $clog2(DECIM),
    localparam int TP_W        = $clog2(TAPS),
    localparam int AW          = CH_W + PH_W + TP_W
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                hist_we,
    output logic [AW-1:0]       hist_waddr,
    output logic [SAMPLE_W-1:0] hist_wdata,
    output logic                hist_re,
    output logic [AW-1:0]       hist_raddr,
    output logic [TP_W+PH_W-1:0] coef_raddr,
    output logic                mac_valid,
    output logic                mac_first,
    output logic                mac_last,
    output logic [CH_W-1:0]     mac_chan
);

    state_t state;
    state_t next_state;

    logic [TP_W-1:0] k;
    logic [TP_W-1:0] k_nxt;
    logic            k_last;
    logic            accept;
    logic            adv;

    logic [CH_W-1:0] chan;
    logic [PH_W-1:0] phase;
    logic [TP_W-1:0] slot;

    logic                 hist_we_d;
    logic [AW-1:0]        hist_waddr_d;
    logic                 mac_valid_d;
    logic [AW-1:0]        hist_raddr_d;
    logic [TP_W+PH_W-1:0] coef_raddr_d;
    logic                 mac_first_d;
    logic                 mac_last_d;
    logic [CH_W-1:0]      mac_chan_d;

    assign k_last = (k == TP_W'(TAPS - 1));
    assign accept = (state == IDLE) && s_valid;
    assign adv    = (state == MAC) && k_last;

    // k is the tap of the command currently on the outputs; k_nxt is the
    // tap of the command being registered at the coming edge.
    assign k_nxt = (state == MAC) ? k + TP_W'(1) : '0;

    // Combinational so it is low throughout reset and high in the very
    // first cycle after release; reset also beats a simultaneous s_valid.
    assign s_ready = (state == IDLE) && !ap_rst;

    pfb_sched_counters #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .DECIM        (DECIM),
        .TAPS         (TAPS),
        .CH_W         (CH_W),
        .PH_W         (PH_W),
        .TP_W         (TP_W)
    ) u_counters (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .adv    (adv),
        .chan   (chan),
        .phase  (phase),
        .slot   (slot)
    );

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= next_state;
            k     <= k_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (s_valid) next_state = WRITE;
            WRITE:   next_state = MAC;
            MAC:     if (k_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: every command field is formed from the state being
    // entered so the outputs can be registered without a cycle of skew.
    // The position counters only move when leaving MAC, so they are
    // stable whenever WRITE or MAC is being entered.
    always_comb begin
        hist_we_d    = (next_state == WRITE);
        hist_waddr_d = hist_waddr;
        mac_valid_d  = (next_state == MAC);
        hist_raddr_d = hist_raddr;
        coef_raddr_d = coef_raddr;
        mac_chan_d   = mac_chan;
        mac_first_d  = 1'b0;
        mac_last_d   = 1'b0;
        if (hist_we_d) begin
            hist_waddr_d = {chan, phase, slot};
        end
        if (mac_valid_d) begin
            // Tap k of phase p reads the sample written k visits ago.
            hist_raddr_d = {chan, phase, slot - k_nxt};
            // ~phase == DECIM-1-phase: newest phase DECIM-1 sample meets h[0].
            coef_raddr_d = {k_nxt, ~phase};
            mac_chan_d   = chan;
            mac_first_d  = (k_nxt == '0) && (phase == '0);
            mac_last_d   = (k_nxt == TP_W'(TAPS - 1)) && (phase == PH_W'(DECIM - 1));
        end
    end

    // Output registers
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            hist_we    <= 1'b0;
            hist_waddr <= '0;
            hist_wdata <= '0;
            hist_re    <= 1'b0;
            hist_raddr <= '0;
            coef_raddr <= '0;
            mac_valid  <= 1'b0;
            mac_first  <= 1'b0;
            mac_last   <= 1'b0;
            mac_chan   <= '0;
        end else begin
            hist_we    <= hist_we_d;
            hist_waddr <= hist_waddr_d;
            hist_re    <= mac_valid_d;
            hist_raddr <= hist_raddr_d;
            coef_raddr <= coef_raddr_d;
            mac_valid  <= mac_valid_d;
            mac_first  <= mac_first_d;
            mac_last   <= mac_last_d;
            mac_chan   <= mac_chan_d;
            if (accept) begin
                hist_wdata <= s_data;
            end
        end
    end

endmodule
